// File: rtl/servant_uart_rx_pkg.sv
// Shared definitions for the servant UART receiver: FSM encoding, oversample
// rate, sample phases and the majority-vote helper.
package servant_uart_rx_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StBreak
   } rx_state_e;

   localparam int unsigned OVERSAMPLE = 16;

   // Bit value is voted from three samples around the bit centre.
   localparam logic [3:0] SAMPLE_PHASE_A = 4'd7;
   localparam logic [3:0] SAMPLE_PHASE_B = 4'd8;
   localparam logic [3:0] SAMPLE_PHASE_C = 4'd9;
   localparam logic [3:0] LAST_PHASE     = 4'd15;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/servant_uart_rx_tick.sv
// Oversample tick generator: one-cycle tick every TICK_DIV clocks, with a
// synchronous clear used to align the tick grid to a start-bit edge.
module servant_uart_rx_tick #(
   parameter int unsigned TICK_DIV = 34
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   output logic o_tick
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   generate
      if (TICK_DIV < 2) begin : g_div_check
         $error("servant_uart_rx_tick: TICK_DIV must be at least 2");
      end
   endgenerate

   logic [CNT_W-1:0] r_cnt;

   assign o_tick = (r_cnt == CNT_LAST);

   // Divider counter: wraps on tick, forced to zero by clear.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_cnt <= '0;
      end else if (i_clear || o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/servant_uart_rx_led.sv
// 8N1 receiver for the servant SoC UART output. Delivers bytes on a
// valid/ready port, flags bad stop bits and dropped bytes, and shows the low
// six bits of the last byte on active-low LEDs when SERVANT_UART_RX_LED_EN is
// defined (otherwise the LEDs are held off).
module servant_uart_rx_led
   import servant_uart_rx_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 32000000,
   parameter int unsigned BAUD        = 57600
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic [5:0] o_led
);

   localparam int unsigned TICK_DIV = CLK_FREQ_HZ / (BAUD * OVERSAMPLE);

   rx_state_e  r_state;
   rx_state_e  w_state_next;
   logic       r_sync1;
   logic       r_sync2;
   logic       r_rx_prev;
   logic [3:0] r_phase;
   logic       r_samp_a;
   logic       r_samp_b;
   logic [2:0] r_bit_idx;
   logic [7:0] r_shift;
   logic [7:0] r_data;
   logic       r_valid;
   logic       r_frame_err;
   logic       r_overrun;

   logic w_rx_s;
   logic w_fall;
   logic w_tick;
   logic w_vote;
   logic w_clear;
   logic w_deliver;
   logic w_bad_stop;
   logic w_load;

   assign w_rx_s = r_sync2;
   assign w_fall = r_rx_prev & ~w_rx_s;
   assign w_vote = majority3(r_samp_a, r_samp_b, w_rx_s);
   // A good byte loads unless the previous one is still pending and not accepted now.
   assign w_load = w_deliver & (~r_valid | i_ready);

   servant_uart_rx_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (w_clear),
      .o_tick  (w_tick)
   );

   // Two-flop synchronizer plus one history flop for falling-edge detection.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_sync1   <= i_rx;
         r_sync2   <= r_sync1;
         r_rx_prev <= r_sync2;
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state and per-cycle strobes; all decisions are taken on ticks.
   always_comb begin
      w_state_next = r_state;
      w_clear      = 1'b0;
      w_deliver    = 1'b0;
      w_bad_stop   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_fall) begin
               w_state_next = StStart;
               w_clear      = 1'b1;
            end
         end
         StStart: begin
            if (w_tick) begin
               if (r_phase == SAMPLE_PHASE_C && w_vote) begin
                  w_state_next = StIdle;
               end else if (r_phase == LAST_PHASE) begin
                  w_state_next = StData;
               end
            end
         end
         StData: begin
            if (w_tick && r_phase == LAST_PHASE && r_bit_idx == 3'd7) begin
               w_state_next = StStop;
            end
         end
         StStop: begin
            if (w_tick && r_phase == SAMPLE_PHASE_C) begin
               if (w_vote) begin
                  w_deliver    = 1'b1;
                  w_state_next = StIdle;
               end else begin
                  w_bad_stop   = 1'b1;
                  w_state_next = StBreak;
               end
            end
         end
         StBreak: begin
            if (w_rx_s) begin
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Bit timing: phase counter, centre samples, bit index and shift register.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_phase   <= '0;
         r_samp_a  <= 1'b0;
         r_samp_b  <= 1'b0;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else if (w_clear) begin
         r_phase   <= '0;
         r_bit_idx <= '0;
      end else if (w_tick) begin
         r_phase <= r_phase + 4'd1;
         if (r_phase == SAMPLE_PHASE_A) begin
            r_samp_a <= w_rx_s;
         end
         if (r_phase == SAMPLE_PHASE_B) begin
            r_samp_b <= w_rx_s;
         end
         if (r_state == StData && r_phase == SAMPLE_PHASE_C) begin
            r_shift <= {w_vote, r_shift[7:1]};
         end
         if (r_state == StData && r_phase == LAST_PHASE) begin
            r_bit_idx <= r_bit_idx + 3'd1;
         end
      end
   end

   // Output port: byte hand-off, frame-error pulse and sticky overrun.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= w_bad_stop;
         if (w_load) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else begin
            if (w_deliver) begin
               r_overrun <= 1'b1;
            end
            if (r_valid && i_ready) begin
               r_valid <= 1'b0;
            end
         end
      end
   end

`ifdef SERVANT_UART_RX_LED_EN
   logic [5:0] r_led;

   // LED register follows each loaded byte, active low.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_led <= 6'h3F;
      end else if (w_load) begin
         r_led <= ~r_shift[5:0];
      end
   end

   assign o_led = r_led;
`else
   assign o_led = 6'h3F;
`endif

   assign o_data      = r_data;
   assign o_valid     = r_valid;
   assign o_frame_err = r_frame_err;
   assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_servant_uart_rx_led.sv
// Directed bench for servant_uart_rx_led. Runs at 250 kbaud from 32 MHz so the
// divider is 8 and one bit lasts 128 clocks. LED expectations follow
// SERVANT_UART_RX_LED_EN.
`timescale 1ns/1ps
module tb_servant_uart_rx_led;

   localparam int unsigned CLK_FREQ_HZ = 32_000_000;
   localparam int unsigned BAUD        = 250_000;
   localparam int          BIT_CLKS    = 128;
   // Start edge driven at negedge 0; sync (2) + edge (1) + 154 ticks of 8 clocks
   // puts the stop-bit vote on posedge 1235, so ready goes high at negedge 1234.
   localparam int          READY_AT_VOTE = 1234;

   logic       clk;
   logic       i_rst;
   logic       i_rx;
   logic       i_ready;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_frame_err;
   logic       o_overrun;
   logic [5:0] o_led;

   servant_uart_rx_led #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ),
      .BAUD        (BAUD)
   ) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_rx        (i_rx),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_frame_err (o_frame_err),
      .o_overrun   (o_overrun),
      .o_led       (o_led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Event monitors, sampled on the inactive edge.
   int   n_valid_rise = 0;
   int   n_valid_fall = 0;
   int   n_valid_cyc  = 0;
   int   n_ferr       = 0;
   int   n_led_on     = 0;
   logic prev_valid   = 1'b0;

   always @(negedge clk) begin
      if (o_valid && !prev_valid) n_valid_rise++;
      if (!o_valid && prev_valid) n_valid_fall++;
      if (o_valid) n_valid_cyc++;
      if (o_frame_err) n_ferr++;
      if (o_led !== 6'h3F) n_led_on++;
      prev_valid = o_valid;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] led_exp(input logic [7:0] d);
`ifdef SERVANT_UART_RX_LED_EN
      return ~d[5:0];
`else
      return 6'h3F;
`endif
   endfunction

   task automatic idle_bits(input int n);
      i_rx = 1'b1;
      repeat (n * BIT_CLKS) @(negedge clk);
   endtask

   // Drives one 8N1 frame; optional one-cycle ready pulse at negedge ready_at.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int ready_at);
      logic [9:0] frame;
      frame = {stop_bit, d, 1'b0};
      for (int c = 0; c < 10 * BIT_CLKS; c++) begin
         @(negedge clk);
         i_rx = frame[c / BIT_CLKS];
         if (ready_at >= 0 && c == ready_at) i_ready = 1'b1;
         else if (ready_at >= 0 && c == ready_at + 1) i_ready = 1'b0;
      end
   endtask

   int rise0;
   int fall0;
   int cyc0;
   int ferr0;

   initial begin
      i_rx    = 1'b1;
      i_ready = 1'b1;
      i_rst   = 1'b0;
      repeat (5) @(negedge clk);
      check("reset_data", o_data, 8'h00);
      check("reset_valid", o_valid, 1'b0);
      check("reset_ferr", o_frame_err, 1'b0);
      check("reset_overrun", o_overrun, 1'b0);
      check("reset_led", o_led, 6'h3F);
      i_rst = 1'b1;
      idle_bits(2);

      // Good byte, consumer always ready.
      rise0 = n_valid_rise; cyc0 = n_valid_cyc; ferr0 = n_ferr;
      send_frame(8'h55, 1'b1, -1);
      idle_bits(1);
      check("good_data", o_data, 8'h55);
      check("good_valid_rises", n_valid_rise - rise0, 1);
      check("good_valid_cycles", n_valid_cyc - cyc0, 1);
      check("good_valid_now", o_valid, 1'b0);
      check("good_led", o_led, led_exp(8'h55));
      check("good_no_ferr", n_ferr - ferr0, 0);

      // Two-clock start glitch.
      rise0 = n_valid_rise; ferr0 = n_ferr;
      @(negedge clk);
      i_rx = 1'b0;
      repeat (2) @(negedge clk);
      i_rx = 1'b1;
      idle_bits(2);
      check("glitch_no_valid", n_valid_rise - rise0, 0);
      check("glitch_no_ferr", n_ferr - ferr0, 0);
      check("glitch_data_kept", o_data, 8'h55);

      // Bad stop bit followed by a long low line.
      rise0 = n_valid_rise; ferr0 = n_ferr;
      send_frame(8'hA3, 1'b0, -1);
      i_rx = 1'b0;
      repeat (3 * BIT_CLKS) @(negedge clk);
      idle_bits(2);
      check("ferr_one_pulse", n_ferr - ferr0, 1);
      check("ferr_no_valid", n_valid_rise - rise0, 0);
      check("ferr_data_kept", o_data, 8'h55);

      rise0 = n_valid_rise; ferr0 = n_ferr;
      send_frame(8'h41, 1'b1, -1);
      idle_bits(1);
      check("after_break_data", o_data, 8'h41);
      check("after_break_valid", n_valid_rise - rise0, 1);
      check("after_break_no_ferr", n_ferr - ferr0, 0);
      check("after_break_led", o_led, led_exp(8'h41));

      // Overrun: two bytes with no consumer.
      i_ready = 1'b0;
      rise0 = n_valid_rise;
      send_frame(8'h31, 1'b1, -1);
      idle_bits(1);
      send_frame(8'h32, 1'b1, -1);
      idle_bits(1);
      check("ovr_data", o_data, 8'h31);
      check("ovr_valid", o_valid, 1'b1);
      check("ovr_flag", o_overrun, 1'b1);
      check("ovr_led", o_led, led_exp(8'h31));
      check("ovr_one_load", n_valid_rise - rise0, 1);
      @(negedge clk);
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      check("ovr_accept_clears_valid", o_valid, 1'b0);
      check("ovr_sticky", o_overrun, 1'b1);
      check("ovr_data_after_accept", o_data, 8'h31);

      // Accept and new load on the same cycle.
      i_rst = 1'b0;
      repeat (2) @(negedge clk);
      i_rst = 1'b1;
      check("sim_overrun_cleared", o_overrun, 1'b0);
      idle_bits(1);
      send_frame(8'h11, 1'b1, -1);
      idle_bits(1);
      check("sim_first_pending", o_valid, 1'b1);
      check("sim_first_data", o_data, 8'h11);
      fall0 = n_valid_fall;
      send_frame(8'h7E, 1'b1, READY_AT_VOTE);
      idle_bits(1);
      check("sim_valid_held", o_valid, 1'b1);
      check("sim_valid_never_dropped", n_valid_fall - fall0, 0);
      check("sim_data", o_data, 8'h7E);
      check("sim_no_overrun", o_overrun, 1'b0);
      check("sim_led", o_led, led_exp(8'h7E));

      // Reset in the middle of data bit 4 of 0xFF.
      rise0 = n_valid_rise;
      @(negedge clk);
      i_rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      i_rx = 1'b1;
      repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
      i_rst = 1'b0;
      #1;
      check("midrst_data", o_data, 8'h00);
      check("midrst_valid", o_valid, 1'b0);
      check("midrst_ferr", o_frame_err, 1'b0);
      check("midrst_overrun", o_overrun, 1'b0);
      check("midrst_led", o_led, 6'h3F);
      repeat (3) @(negedge clk);
      i_rst = 1'b1;
      idle_bits(6);
      check("midrst_no_delivery", n_valid_rise - rise0, 0);
      check("midrst_valid_after", o_valid, 1'b0);

      i_ready = 1'b1;
      rise0 = n_valid_rise;
      send_frame(8'h0F, 1'b1, -1);
      idle_bits(1);
      check("post_rst_data", o_data, 8'h0F);
      check("post_rst_valid", n_valid_rise - rise0, 1);
      check("post_rst_led", o_led, led_exp(8'h0F));
`ifndef SERVANT_UART_RX_LED_EN
      check("led_off_throughout", n_led_on, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
